// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant codes and byte-enable constants.
// Pure declarations; no logic and no latency.
// Backpressure is not applicable here; consumers own all handshaking.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2,
        GNT_G    = 2'd3
    } grant_e;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational priority picker: debug > data > fetch, with fetch promoted above data when starved.
// Zero latency.
// Backpressure is not applicable; the caller decides when the pick is consumed.
module arb_priority
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   g_req_i,
    input  logic   starve_i,
    output grant_e grant_o
);

    always_comb begin
        grant_o = GNT_NONE;
        if (g_req_i) begin
            grant_o = GNT_G;
        end else if (i_req_i && starve_i) begin
            grant_o = GNT_I;
        end else if (d_req_i) begin
            grant_o = GNT_D;
        end else if (i_req_i) begin
            grant_o = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM among fetch, data and debug requesters.
// Latency: req seen in IDLE at T gives ack at T+MEM_LATENCY+2; next grant no earlier than T+MEM_LATENCY+3.
// Backpressure: requesters hold req until their one-cycle ack; stall_o freezes the pipeline meanwhile.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_req_i,
    input  logic [31:0]       i_addr_i,
    output logic              i_ack_o,
    output logic [31:0]       i_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_ack_o,
    output logic [31:0]       d_rdata_o,

    input  logic              g_req_i,
    input  logic              g_we_i,
    input  logic [31:0]       g_addr_i,
    input  logic [31:0]       g_wdata_i,
    output logic              g_ack_o,
    output logic [31:0]       g_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,

    output logic              stall_o,
    output logic              busy_o
);

    localparam logic [2:0] WAIT_INIT  = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e             state_q,      state_d;
    grant_e             grant_q,      grant_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic               we_q,         we_d;
    logic [3:0]         be_q,         be_d;
    logic [31:0]        wdata_q,      wdata_d;
    logic [2:0]         wait_cnt_q,   wait_cnt_d;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [31:0]        i_rdata_q,    i_rdata_d;
    logic [31:0]        d_rdata_q,    d_rdata_d;
    logic [31:0]        g_rdata_q,    g_rdata_d;

    grant_e             pick;
    logic               starved;

    // Byte-offset bits and bits above the RAM's reach never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[1:0], d_addr_i[1:0], g_addr_i[1:0],
                                i_addr_i[31:ADDR_W+2], d_addr_i[31:ADDR_W+2],
                                g_addr_i[31:ADDR_W+2]};

    assign starved = (starve_cnt_q == STARVE_MAX);

    arb_priority u_arb_priority (
        .i_req_i  (i_req_i),
        .d_req_i  (d_req_i),
        .g_req_i  (g_req_i),
        .starve_i (starved),
        .grant_o  (pick)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        g_rdata_d    = g_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!i_req_i) begin
                    starve_cnt_d = 4'd0;
                end
                if (pick != GNT_NONE) begin
                    grant_d = pick;
                    state_d = ST_ISSUE;
                end
                case (pick)
                    GNT_I: begin
                        addr_d       = i_addr_i[ADDR_W+1:2];
                        we_d         = 1'b0;
                        be_d         = BE_NONE;
                        wdata_d      = 32'd0;
                        starve_cnt_d = 4'd0;
                    end
                    GNT_D: begin
                        addr_d  = d_addr_i[ADDR_W+1:2];
                        we_d    = d_we_i;
                        be_d    = d_we_i ? d_be_i : BE_NONE;
                        wdata_d = d_wdata_i;
                        // Count data wins only while fetch is actually waiting.
                        if (i_req_i && (starve_cnt_q != STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                    GNT_G: begin
                        addr_d  = g_addr_i[ADDR_W+1:2];
                        we_d    = g_we_i;
                        be_d    = g_we_i ? BE_FULL : BE_NONE;
                        wdata_d = g_wdata_i;
                    end
                    default: ;
                endcase
            end

            ST_ISSUE: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        case (grant_q)
                            GNT_I:   i_rdata_d = mem_rdata_i;
                            GNT_D:   d_rdata_d = mem_rdata_i;
                            GNT_G:   g_rdata_d = mem_rdata_i;
                            default: ;
                        endcase
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= BE_NONE;
            wdata_q      <= 32'd0;
            wait_cnt_q   <= 3'd0;
            starve_cnt_q <= 4'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            g_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            g_rdata_q    <= g_rdata_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign mem_en_o    = (state_q == ST_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign i_ack_o = (state_q == ST_DONE) && (grant_q == GNT_I);
    assign d_ack_o = (state_q == ST_DONE) && (grant_q == GNT_D);
    assign g_ack_o = (state_q == ST_DONE) && (grant_q == GNT_G);

    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
    assign g_rdata_o = g_rdata_q;

    assign stall_o = (i_req_i & ~i_ack_o)
                   | (d_req_i & ~d_ack_o)
                   | (busy_o & (grant_q == GNT_G));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, word-wide synchronous memory among three requesters:
  - instruction fetch (IF stage),
  - data load/store (MEM stage),
  - debug/loader port (program load and inspection).
- Sits between the cpu top level and the unified RAM.
- Sequences each access through a small FSM.
- Produces a stall that the pipeline uses to freeze while its access is outstanding.

Parameters:
- ADDR_W, 12, memory word-address width.
- MEM_LATENCY, 1, cycles from mem_en_o to valid mem_rdata_i; legal range 1..7.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- i_req_i  in  1  fetch request; held until i_ack_o.
- i_addr_i  in  32  fetch byte address.
- i_ack_o  out  1  one-cycle completion pulse.
- i_rdata_o  out  32  fetched word.
- d_req_i  in  1  data request; held until d_ack_o.
- d_we_i  in  1  1 = store.
- d_be_i  in  4  store byte enables.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  store data.
- d_ack_o  out  1  completion pulse.
- d_rdata_o  out  32  load word.
- g_req_i  in  1  debug request; held until g_ack_o.
- g_we_i  in  1  debug write.
- g_addr_i  in  32  debug byte address.
- g_wdata_i  in  32  debug write data; full word written.
- g_ack_o  out  1  completion pulse.
- g_rdata_o  out  32  debug read word.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  ADDR_W  word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data.
- stall_o  out  1  pipeline stall.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset state:
  - FSM returns to IDLE.
  - All acks, mem_en_o, mem_we_o and busy_o are 0.
  - mem_be_o, mem_addr_o, mem_wdata_o, all rdata_o and starve_cnt are 0.
  - grant register is cleared.
- Reset mid-access: the access is abandoned and no ack is issued. The requester must re-request; the bench checks that no ack appears.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, register the winner and its addr/we/be/wdata, then go to ISSUE. Otherwise stay in IDLE.
  - Priority: debug > data > fetch.
  - Exception: if starve_cnt == STARVE_LIMIT and i_req_i is high, fetch wins over data. Debug still wins.
- starve_cnt:
  - Increments on each data grant made while i_req_i is high, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, or in any IDLE arbitration cycle with i_req_i low.
- ISSUE (one cycle):
  - mem_en_o = 1.
  - mem_addr_o = addr[ADDR_W+1:2]; byte-address bits [1:0] are ignored.
  - mem_we_o = winner's we (always 0 for fetch).
  - mem_be_o = d_be_i for data, 4'hF for debug, 4'h0 for reads.
  - mem_wdata_o = winner's wdata.
- WAIT:
  - Counter waits MEM_LATENCY cycles after ISSUE.
  - mem_en_o = 0; the mem_* outputs hold their values.
  - Writes wait the same duration, so all accesses have uniform timing.
- DONE (one cycle):
  - The winner's ack is 1.
  - On a read, the winner's rdata_o shows the word captured from mem_rdata_i at the end of WAIT.
  - Next state is IDLE. No arbitration happens in DONE, so the acked requester's still-high req is ignored.
- rdata_o values are updated only by a read to that port and hold otherwise.
- Latency: a req first seen in IDLE at cycle T produces ack at T+MEM_LATENCY+2. The next grant is at the earliest T+MEM_LATENCY+3.
- stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o) | (busy_o & grant==debug). It is combinational from the registers and inputs.
- busy_o = (state != IDLE).
- Simultaneous requests are resolved only in IDLE. A request that arrives while busy waits; it is never lost as long as req is held.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, DONE);
  - the grant encoding (GNT_NONE, GNT_I, GNT_D, GNT_G);
  - the constant BE_FULL = 4'hF.
- One natural sub-module, arb_priority: a combinational priority picker. It takes the three reqs plus a starve flag and returns a grant code, so it can be verified in isolation.

Test Plan:
- Reset/idle: reset_n=0 for 2 cycles with all reqs high → all acks=0, mem_en_o=0, busy_o=0. After release, the first grant goes to debug.
- Single fetch (MEM_LATENCY=1): i_req at cycle 0 with addr 0x10 → mem_en_o=1 and mem_addr_o=4 at cycle 1; i_ack_o=1 at cycle 3 with i_rdata_o = the memory word at 4.
- Store with byte enables: d_we=1, d_be=4'b0011, addr 0x20, wdata 0xDEADBEEF → mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=8, d_ack_o at cycle 3; a later read of 0x20 returns the low half 0xBEEF merged with the prior word.
- Simultaneous d_req and i_req, both held continuously (STARVE_LIMIT=4) → grants D, D, D, D, I, D…; stall_o stays 1 throughout.
- Debug preemption: g_req arrives while a fetch is in WAIT → the fetch completes first, then debug is granted ahead of a pending data request; stall_o=1 while debug is busy.
- Reset asserted during WAIT → next cycle is IDLE, no ack pulse, mem_en_o=0; a re-requested access then completes normally.
